// File: rtl/fir_inverse_filter.sv
// Inverse filter for the 4-tap FIR h={1,2,3,4}.
// One shared multiplier; valid/ready on both sides.
module fir_inverse_filter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter logic signed [7:0] H1 = 8'sd2,
  parameter logic signed [7:0] H2 = 8'sd3,
  parameter logic signed [7:0] H3 = 8'sd4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] x_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf
);

  localparam int ACC_W  = IN_W + 4;
  localparam int PROD_W = 8 + OUT_W;
  localparam logic signed [ACC_W-1:0] MAX_V =
    ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state;
  logic [1:0] k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  hist1, hist2, hist3;
  logic signed [7:0]        coef;
  logic signed [OUT_W-1:0]  tap;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  r;
  logic                     r_hi, r_lo;
  logic signed [OUT_W-1:0]  x_sat;

  assign in_ready = (state == IDLE);

  always_comb begin
    coef = H3;
    tap  = hist3;
    case (k)
      2'd1: begin
        coef = H1;
        tap  = hist1;
      end
      2'd2: begin
        coef = H2;
        tap  = hist2;
      end
      default: begin
        coef = H3;
        tap  = hist3;
      end
    endcase
  end

  assign prod     = coef * tap;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign r        = acc - prod_ext;
  assign r_hi     = (r > MAX_V);
  assign r_lo     = (r < MIN_V);

  always_comb begin
    x_sat = r[OUT_W-1:0];
    if (r_hi) x_sat = MAX_V[OUT_W-1:0];
    if (r_lo) x_sat = MIN_V[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      acc       <= '0;
      hist1     <= '0;
      hist2     <= '0;
      hist3     <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      k         <= 2'd0;
      acc       <= '0;
      hist1     <= '0;
      hist2     <= '0;
      hist3     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= {{(ACC_W-IN_W){y_in[IN_W-1]}}, y_in};
            k     <= 2'd1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= r;
          if (k == 2'd3) begin
            x_out     <= x_sat;
            ovf       <= r_hi | r_lo;
            out_valid <= 1'b1;
            k         <= 2'd0;
            state     <= OUT;
          end else begin
            k <= k + 2'd1;
          end
        end
        OUT: begin
          // history advances only once the sample really leaves
          if (out_ready) begin
            hist3     <= hist2;
            hist2     <= hist1;
            hist1     <= x_out;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Directed bench for fir_inverse_filter.
// Inputs change and outputs are sampled on the falling edge.
module tb_fir_inverse_filter;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic signed [15:0] y_in;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_out;
  logic              out_valid;
  logic              out_ready;
  logic              ovf;

  int ncmp = 0;
  int nfail = 0;

  fir_inverse_filter dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // called at a falling edge; returns at the falling edge after accept
  task automatic send(input int y);
    int n = 0;
    y_in = 16'(y);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept_timeout", int'(n < 20), 1);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("out_timeout", int'(n < 20), 1);
  endtask

  task automatic recv(input string tag, input int ex, input int eo);
    wait_out();
    chk(tag, int'(x_out), ex);
    chk({tag, "_ovf"}, int'(ovf), eo);
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int ys[8];
    int xs[8];
    int acc_q[$];
    int out_q[$];
    int seen;
    ys = '{1, 4, 10, 20, 25, 25, 18, 3};
    xs = '{1, 2, 3, 4, 0, 1, 0, 0};
    rst = 1'b1;
    clr = 1'b0;
    y_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // reset
    @(negedge clk);
    chk("rst_x", int'(x_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);

    // loopback
    for (int i = 0; i < 8; i++) begin
      send(ys[i]);
      recv($sformatf("loop%0d", i), xs[i], 0);
    end

    // timing with in_valid held high
    y_in = 16'sd0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) acc_q.push_back(i);
      if (out_valid) out_q.push_back(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("tim_nacc", acc_q.size(), 4);
    chk("tim_nout", out_q.size(), 4);
    if (acc_q.size() == 4 && out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tim_acc%0d", i), acc_q[i], 5 * i);
        chk($sformatf("tim_out%0d", i), out_q[i], 5 * i + 4);
      end
    end

    // clear history before backpressure
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // backpressure
    out_ready = 1'b0;
    send(2);
    wait_out();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (x_out !== 8'sd2 || !out_valid || in_ready) seen++;
      @(negedge clk);
    end
    chk("bp_stable", seen, 0);
    recv("bp_x", 2, 0);
    chk("bp_drop", int'(out_valid), 0);
    send(4);
    recv("bp_next", 0, 0);

    // flush during MAC; history is now {0,2,0}
    send(7);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b1;
    y_in = 16'sd9;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("clr_no_out", seen, 0);
    send(5);
    recv("clr_next", 5, 0);

    // reset while output pending
    out_ready = 1'b0;
    send(3);
    wait_out();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_x", int'(x_out), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_ready", int'(in_ready), 1);

    // saturation
    send(200);
    recv("sat_hi", 127, 1);
    send(0);
    recv("sat_lo", -128, 1);
    chk("sat_ovf_clr", int'(ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
